murphi_rule_scheduler: RTL and testbench

Rule-firing scheduler that drives the `io_en_a` rule-select input of a Murphi-derived `system` block. Each cycle it reads the guard vector computed from the system's current state and picks one enabled rule in round-robin order. It then issues that rule for exactly one cycle. It also counts firings and flags deadlock when no guard is enabled for too long. It sits beside `system` in simulation and emulation builds and replaces free-running testbench stimulus.

---
 rtl/murphi_rule_scheduler_pkg.sv | 24 ++
 rtl/murphi_rule_scheduler_rr_pick.sv | 38 +++
 rtl/murphi_rule_scheduler.sv | 152 +++++++++++++++
 tb/tb_murphi_rule_scheduler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/murphi_rule_scheduler_pkg.sv
// Shared types and constants for the Murphi rule scheduler.
package rule_sched_pkg;

  localparam int unsigned RULE_ID_W  = 4;
  localparam int unsigned FIRE_CNT_W = 16;
  localparam int unsigned STALL_W    = 8;

  localparam int unsigned          LFSR_W    = 8;
  localparam logic [LFSR_W-1:0]    LFSR_SEED = 8'h01;
  // Taps 8,6,5,4 of a Fibonacci LFSR, as bit positions 7,5,4,3.
  localparam logic [LFSR_W-1:0]    LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StIssue,
    StHalt
  } sched_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/murphi_rule_scheduler_rr_pick.sv
// Rotate-priority encoder: first set guard bit at or after start, wrapping modulo NUM_RULES.
module rr_pick
  import rule_sched_pkg::*;
#(
  parameter int unsigned NUM_RULES = 12
) (
  input  logic [NUM_RULES-1:0]  guard,
  input  logic [RULE_ID_W-1:0]  start,
  output logic                  found,
  output logic [RULE_ID_W-1:0]  index
);

  localparam logic [RULE_ID_W:0] NumRulesW = (RULE_ID_W + 1)'(NUM_RULES);

  logic [2*NUM_RULES-1:0] doubled;
  logic [NUM_RULES-1:0]   rotated;
  logic [RULE_ID_W-1:0]   offset;
  logic [RULE_ID_W:0]     sum;

  always_comb begin
    doubled = {guard, guard} >> start;
    rotated = doubled[NUM_RULES-1:0];
    found   = 1'b0;
    offset  = '0;
    for (int i = 0; i < int'(NUM_RULES); i++) begin
      if (!found && rotated[i]) begin
        found  = 1'b1;
        offset = RULE_ID_W'(i);
      end
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= NumRulesW) begin
      sum = sum - NumRulesW;
    end
    index = found ? sum[RULE_ID_W-1:0] : '0;
  end

endmodule

// File: rtl/murphi_rule_scheduler.sv
// Rule-firing scheduler for the Murphi `system` block: round-robin pick, one-cycle issue, deadlock.
// Define SCHED_LFSR_EN to start each search from an LFSR instead of the round-robin pointer.
module murphi_rule_scheduler
  import rule_sched_pkg::*;
#(
  parameter int unsigned NUM_RULES      = 12,
  parameter int unsigned DEADLOCK_LIMIT = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_run,
  input  logic [NUM_RULES-1:0]   io_guard,
  output logic [RULE_ID_W-1:0]   io_en_a,
  output logic [FIRE_CNT_W-1:0]  io_fire_count,
  output logic                   io_deadlock
);

  localparam logic [RULE_ID_W-1:0] LastRule   = RULE_ID_W'(NUM_RULES - 1);
  localparam logic [STALL_W-1:0]   StallLimit = STALL_W'(DEADLOCK_LIMIT);

  if (NUM_RULES < 1 || NUM_RULES > 15) begin : gen_bad_num_rules
    $error("NUM_RULES must be in 1..15");
  end
  if (DEADLOCK_LIMIT < 1 || DEADLOCK_LIMIT > 255) begin : gen_bad_limit
    $error("DEADLOCK_LIMIT must be in 1..255");
  end

  sched_state_e            state_q, state_d;
  logic [RULE_ID_W-1:0]    sel_q, sel_d;
  logic [RULE_ID_W-1:0]    en_q, en_d;
  logic [STALL_W-1:0]      stall_q, stall_d;
  logic [FIRE_CNT_W-1:0]   fire_q, fire_d;
  logic                    dead_q, dead_d;
  logic [RULE_ID_W-1:0]    start;
  logic                    pick_found;
  logic [RULE_ID_W-1:0]    pick_idx;

`ifdef SCHED_LFSR_EN
  localparam logic [RULE_ID_W-1:0] NumRules4 = RULE_ID_W'(NUM_RULES);

  if (NUM_RULES < 8 || NUM_RULES > 15) begin : gen_bad_lfsr_rules
    $error("LFSR start selection needs 8 <= NUM_RULES <= 15");
  end

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = (state_q == StSelect) ? lfsr_step(lfsr_q) : lfsr_q;
    // With NUM_RULES >= 8 a single subtraction brings any 4-bit value into range.
    start  = (lfsr_q[RULE_ID_W-1:0] >= NumRules4) ? lfsr_q[RULE_ID_W-1:0] - NumRules4
                                                   : lfsr_q[RULE_ID_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  logic [RULE_ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    start = ptr_q;
    ptr_d = ptr_q;
    if (state_q == StIssue) begin
      ptr_d = (sel_q == LastRule) ? '0 : sel_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  rr_pick #(
    .NUM_RULES (NUM_RULES)
  ) u_rr_pick (
    .guard (io_guard),
    .start (start),
    .found (pick_found),
    .index (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = '0;
    stall_d = stall_q;
    fire_d  = fire_q;
    dead_d  = dead_q;
    unique case (state_q)
      StIdle: begin
        if (io_run) begin
          state_d = StSelect;
        end
      end
      StSelect: begin
        if (!io_run) begin
          state_d = StIdle;
        end else if (pick_found) begin
          sel_d   = pick_idx;
          en_d    = pick_idx + 1'b1;
          stall_d = '0;
          state_d = StIssue;
        end else begin
          stall_d = stall_q + 1'b1;
          if (stall_d == StallLimit) begin
            dead_d  = 1'b1;
            state_d = StHalt;
          end
        end
      end
      StIssue: begin
        fire_d  = (fire_q == '1) ? fire_q : fire_q + 1'b1;
        state_d = StSelect;
      end
      StHalt: begin
        dead_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      en_q    <= '0;
      stall_q <= '0;
      fire_q  <= '0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      stall_q <= stall_d;
      fire_q  <= fire_d;
      dead_q  <= dead_d;
    end
  end

  assign io_en_a       = en_q;
  assign io_fire_count = fire_q;
  assign io_deadlock   = dead_q;

endmodule

// File: tb/tb_murphi_rule_scheduler.sv
// Scoreboarded bench for murphi_rule_scheduler in its default round-robin build.
module tb_murphi_rule_scheduler;

  logic        clock;
  logic        reset;
  logic        io_run;
  logic [11:0] io_guard;
  logic [3:0]  io_en_a;
  logic [15:0] io_fire_count;
  logic        io_deadlock;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  murphi_rule_scheduler #(
    .NUM_RULES      (12),
    .DEADLOCK_LIMIT (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .io_run        (io_run),
    .io_guard      (io_guard),
    .io_en_a       (io_en_a),
    .io_fire_count (io_fire_count),
    .io_deadlock   (io_deadlock)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    io_run = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  // Every nonzero rule select must match the next expected firing.
  always @(negedge clock) begin
    if (io_en_a != 4'd0) begin
      if (exp_q.size() == 0) check_eq("sb_unexpected", {28'd0, io_en_a}, 32'd0);
      else check_eq("sb_en_a", {28'd0, io_en_a}, {28'd0, exp_q.pop_front()});
    end
  end

  initial begin
    io_guard = '0;
    do_reset();

    // Idle with run low.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_en_a", {28'd0, io_en_a}, 32'd0);
      check_eq("idle_count", {16'd0, io_fire_count}, 32'd0);
      check_eq("idle_dead", {31'd0, io_deadlock}, 32'd0);
    end

    // Single guard; drop run during the ISSUE cycle.
    io_guard = 12'h002;
    exp_q.push_back(4'd2);
    io_run = 1'b1;
    tick();
    check_eq("lat_cycle1", {28'd0, io_en_a}, 32'd0);
    tick();
    check_eq("lat_cycle2", {28'd0, io_en_a}, 32'd2);
    io_run = 1'b0;
    tick();
    check_eq("after_issue_en_a", {28'd0, io_en_a}, 32'd0);
    check_eq("count_one", {16'd0, io_fire_count}, 32'd1);
    tick();
    tick();
    check_eq("run_drop_idle", {28'd0, io_en_a}, 32'd0);
    check_eq("count_hold", {16'd0, io_fire_count}, 32'd1);

    // All guards true: full round-robin sweep plus wrap to rule 1.
    do_reset();
    io_guard = 12'hFFF;
    for (int k = 0; k < 13; k++) exp_q.push_back(4'((k % 12) + 1));
    io_run = 1'b1;
    for (int t = 1; t <= 26; t++) begin
      tick();
      if (t % 2 == 0) check_eq("rr_fire", {28'd0, io_en_a}, 32'((t / 2 - 1) % 12 + 1));
      else check_eq("rr_gap", {28'd0, io_en_a}, 32'd0);
      if (t == 26) io_run = 1'b0;
    end
    tick();
    tick();
    check_eq("rr_count", {16'd0, io_fire_count}, 32'd13);

    // Wrap-around: rule 10 last, then guards {2,11} fire ids 12 then 3.
    do_reset();
    io_guard = 12'h200;
    exp_q.push_back(4'd10);
    io_run = 1'b1;
    tick();
    tick();
    check_eq("wrap_first", {28'd0, io_en_a}, 32'd10);
    io_guard = 12'h804;
    exp_q.push_back(4'd12);
    exp_q.push_back(4'd3);
    tick();
    tick();
    check_eq("wrap_hi", {28'd0, io_en_a}, 32'd12);
    tick();
    tick();
    check_eq("wrap_lo", {28'd0, io_en_a}, 32'd3);
    io_run = 1'b0;
    tick();
    tick();
    check_eq("wrap_count", {16'd0, io_fire_count}, 32'd3);

    // Reset during ISSUE: pointer is 3, so rule id 4 is issued first.
    io_guard = 12'hFFF;
    exp_q.push_back(4'd4);
    io_run = 1'b1;
    tick();
    tick();
    check_eq("rst_issue_en_a", {28'd0, io_en_a}, 32'd4);
    reset = 1'b1;
    tick();
    check_eq("rst_after_en_a", {28'd0, io_en_a}, 32'd0);
    check_eq("rst_after_count", {16'd0, io_fire_count}, 32'd0);
    check_eq("rst_after_dead", {31'd0, io_deadlock}, 32'd0);
    reset  = 1'b0;
    io_run = 1'b0;
    tick();

    // Deadlock after 8 empty SELECT cycles; sticky until reset.
    do_reset();
    io_guard = '0;
    io_run   = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check_eq("pre_deadlock", {31'd0, io_deadlock}, 32'd0);
    end
    tick();
    check_eq("deadlock_rise", {31'd0, io_deadlock}, 32'd1);
    io_guard = 12'hFFF;
    for (int t = 0; t < 5; t++) begin
      tick();
      check_eq("halt_dead", {31'd0, io_deadlock}, 32'd1);
      check_eq("halt_en_a", {28'd0, io_en_a}, 32'd0);
    end
    io_run = 1'b0;
    tick();
    check_eq("halt_run_low", {31'd0, io_deadlock}, 32'd1);
    do_reset();
    check_eq("deadlock_cleared", {31'd0, io_deadlock}, 32'd0);
    tick();

    check_eq("sb_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
